// File: rtl/sa_autosa_cdp_rdma_grp_ctrl_if.sv
// Bus between the CDP RDMA group controller and its register file / datapath.
// Group-level op_en pulses and datapath handshakes in, per-group status and load/interrupt pulses out.
interface sa_autosa_cdp_rdma_grp_ctrl_if;
    logic       producer;
    logic       op_en_set_0;
    logic       op_en_set_1;
    logic       dp_ready;
    logic       dp_done;
    logic       consumer;
    logic [1:0] status_0;
    logic [1:0] status_1;
    logic       op_load;
    logic       op_grp;
    logic [1:0] done_intr;
    logic       busy;

    modport slave (
        input  producer, op_en_set_0, op_en_set_1, dp_ready, dp_done,
        output consumer, status_0, status_1, op_load, op_grp, done_intr, busy
    );

    modport master (
        output producer, op_en_set_0, op_en_set_1, dp_ready, dp_done,
        input  consumer, status_0, status_1, op_load, op_grp, done_intr, busy
    );
endinterface

// File: rtl/sa_autosa_cdp_rdma_grp_ctrl.sv
// Two-group ping-pong controller for the CDP RDMA: tracks op_en per group, loads and runs
// the consumer group on the datapath, and raises a per-group completion interrupt.
module sa_autosa_cdp_rdma_grp_ctrl (
    input  logic                          autosa_core_clk,
    input  logic                          autosa_core_rstn,
    sa_autosa_cdp_rdma_grp_ctrl_if.slave  bus
);
    localparam int unsigned NGRP = 2;
    localparam int unsigned SW   = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [NGRP-1:0]   op_en_q, op_en_d;
    logic              consumer_q, consumer_d;
    logic [NGRP-1:0]   done_intr_q, done_intr_d;

    // producer is informational only
    logic unused_producer;
    assign unused_producer = bus.producer;

    always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
        if (!autosa_core_rstn) begin
            state_q     <= ST_IDLE;
            op_en_q     <= '0;
            consumer_q  <= 1'b0;
            done_intr_q <= '0;
        end else begin
            state_q     <= state_d;
            op_en_q     <= op_en_d;
            consumer_q  <= consumer_d;
            done_intr_q <= done_intr_d;
        end
    end

    // A set on an already-enabled group is absorbed by the OR; completion clear overrides it.
    always_comb begin
        state_d     = state_q;
        op_en_d     = op_en_q | {bus.op_en_set_1, bus.op_en_set_0};
        consumer_d  = consumer_q;
        done_intr_d = '0;
        case (state_q)
            ST_IDLE: begin
                if (op_en_q[consumer_q] && bus.dp_ready) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (bus.dp_done) begin
                    state_d                 = ST_IDLE;
                    op_en_d[consumer_q]     = 1'b0;
                    consumer_d              = ~consumer_q;
                    done_intr_d[consumer_q] = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    function automatic logic [SW-1:0] grp_status(input logic en, input logic is_cons, input logic active);
        if (!en)                  return SW'(0);
        else if (is_cons && active) return SW'(1);
        else                      return SW'(2);
    endfunction

    logic active;
    assign active = (state_q != ST_IDLE);

    assign bus.consumer  = consumer_q;
    assign bus.op_grp    = consumer_q;
    assign bus.op_load   = (state_q == ST_LOAD);
    assign bus.done_intr = done_intr_q;
    assign bus.busy      = active;
    assign bus.status_0  = grp_status(op_en_q[0], (consumer_q == 1'b0), active);
    assign bus.status_1  = grp_status(op_en_q[1], (consumer_q == 1'b1), active);
endmodule

// File: doc/sa_autosa_cdp_rdma_grp_ctrl.md
SA_AUTOSA_CDP_RDMA_GRP_CTRL -- requirements
Module: sa_autosa_cdp_rdma_grp_ctrl

Interface
REQ-001 SHALL: autosa_core_clk  in  1  clock; all flops rising-edge.
REQ-002 SHALL: autosa_core_rstn  in  1  reset, asynchronous, active-low.
REQ-003 SHALL: producer  in  1  group currently programmed by software; informational only, no effect on control.
REQ-004 SHALL: op_en_set_0  in  1  single-cycle pulse, software wrote op_en=1 for group 0.
REQ-005 SHALL: op_en_set_1  in  1  same, group 1.
REQ-006 SHALL: dp_ready  in  1  datapath idle, able to accept a load.
REQ-007 SHALL: dp_done  in  1  single-cycle pulse, datapath finished the current layer.
REQ-008 SHALL: consumer  out  1  group the hardware executes next or is executing; drives register-file consumer field.
REQ-009 SHALL: status_0  out  2  group 0 status: 0 idle, 1 running, 2 pending; 3 never driven.
REQ-010 SHALL: status_1  out  2  group 1 status, same encoding.
REQ-011 SHALL: op_load  out  1  single-cycle pulse, datapath latches config of group op_grp.
REQ-012 SHALL: op_grp  out  1  group selected for load/run; equals consumer.
REQ-013 SHALL: done_intr  out  2  one-hot single-cycle pulse, bit g = group g completed.
REQ-014 SHALL: busy  out  1  high when FSM is not IDLE.

Function
REQ-015 SHALL: hold one op_en flop per group; op_en_set_g sets op_en[g] next cycle only when op_en[g]=0; a set while op_en[g]=1 is dropped without side effect.
REQ-016 SHALL: accept op_en_set_0 and op_en_set_1 in the same cycle, both taking effect.
REQ-017 SHALL: implement FSM with states IDLE, LOAD, RUN.
REQ-018 SHALL: IDLE -> LOAD when op_en[consumer]=1 and dp_ready=1; otherwise remain IDLE; op_en of the non-consumer group never starts execution.
REQ-019 SHALL: LOAD lasts exactly one cycle; op_load=1 only in LOAD (Moore output); LOAD -> RUN unconditionally.
REQ-020 SHALL: RUN -> IDLE on dp_done=1; in the following cycle: op_en[consumer] cleared, consumer toggled, done_intr bit of the completed group pulsed for one cycle.
REQ-021 SHALL: ignore dp_done in IDLE and LOAD.
REQ-022 SHALL: dp_done in RUN coinciding with op_en_set of the running group: set dropped (REQ-015), clear wins.
REQ-023 SHALL: dp_done in RUN coinciding with op_en_set of the other group: both take effect; next IDLE cycle may immediately start that group.
REQ-024 SHALL: latency op_en_set_g pulse at cycle T (g=consumer, FSM IDLE, dp_ready=1) -> op_load at T+2; dp_done at T -> done_intr at T+1; back-to-back pending group -> op_load at T+2.
REQ-025 SHALL: status_g combinational from flops: 0 if op_en[g]=0; 1 if op_en[g]=1, consumer=g and FSM not IDLE; else 2.
REQ-026 SHALL: consumer wraps 1 -> 0 on completion of group 1.

Reset
REQ-027 SHALL: on reset assertion, asynchronously: FSM IDLE, op_en[1:0]=0, consumer=0, op_load=0, done_intr=0, busy=0, status_0=status_1=0.
REQ-028 SHALL: reset mid-operation abandons the run without done_intr; first cycle after deassertion obeys REQ-018 from reset state.

Verification
REQ-029 SHALL: single layer: op_en_set_0 at T, dp_ready=1 -> op_load=1, op_grp=0 at T+2, status_0=1; dp_done at T+10 -> done_intr=01, consumer=1, status_0=0 at T+11.
REQ-030 SHALL: ping-pong: op_en_set_0 and op_en_set_1 both at T -> status_1=2 during group 0 run; dp_done -> op_load with op_grp=1 two cycles after dp_done; second dp_done -> done_intr=10, consumer=0.
REQ-031 SHALL: out-of-order program: only op_en_set_1 with consumer=0 -> no op_load for 20 cycles, status_1=2, busy=0.
REQ-032 SHALL: collisions: op_en_set_0 while group 0 running, then dp_done concurrent with op_en_set_0 -> op_en[0] ends 0, status_0=0, exactly one done_intr.
REQ-033 SHALL: dp_ready=0 with op_en[0]=1 -> FSM stays IDLE, status_0=2; dp_ready rises at T -> op_load at T+1.
REQ-034 SHALL: reset asserted in RUN -> all outputs 0 immediately; no done_intr after release; spurious dp_done in IDLE -> no effect.
